// File: rtl/dlx_pkg.sv
// dlx_pkg: shared DLX definitions used by the ID/EX operand stage.
//   - ALU opcode encodings (5-bit, matching the integer ALU Op input)
//   - REG_ZERO: architectural zero register index
//   - BUBBLE_OP: opcode driven while the EX slot holds no instruction
package dlx_pkg;

   localparam logic [4:0] ALU_AND    = 5'b00000;
   localparam logic [4:0] ALU_OR     = 5'b00001;
   localparam logic [4:0] ALU_ADD    = 5'b00010;
   localparam logic [4:0] ALU_SUB    = 5'b00011;
   localparam logic [4:0] ALU_XOR    = 5'b00100;
   localparam logic [4:0] ALU_SLL    = 5'b00101;
   localparam logic [4:0] ALU_SRL    = 5'b00110;
   localparam logic [4:0] ALU_SLTU   = 5'b00111;
   localparam logic [4:0] ALU_SLT    = 5'b01000;
   localparam logic [4:0] ALU_SGE    = 5'b01001;
   localparam logic [4:0] ALU_SGT    = 5'b01010;
   localparam logic [4:0] ALU_LHI    = 5'b01100;
   localparam logic [4:0] ALU_ADDF   = 5'b01111;
   localparam logic [4:0] ALU_CVTI2F = 5'b11110;
   localparam logic [4:0] ALU_MOV    = 5'b11111;

   localparam logic [4:0] REG_ZERO   = 5'd0;

   // A bubble is valid=0, wr_en=0, is_load=0 with this opcode.
   localparam logic [4:0] BUBBLE_OP  = ALU_AND;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: 3-way priority operand forward select.
//   rs          - source register index of the operand
//   reg_val     - value captured from the register file
//   exm_*       - EX/MEM forwarding source (highest priority)
//   mwb_*       - MEM/WB forwarding source
//   value       - selected operand
// Index 0 is never forwarded; the register file already reads 0 for it.
module fwd_mux
   import dlx_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [DATA_W-1:0] reg_val,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic              exm_wr_en,
   input  logic [DATA_W-1:0] exm_result,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic              mwb_wr_en,
   input  logic [DATA_W-1:0] mwb_data,
   output logic [DATA_W-1:0] value
);

   always_comb begin
      value = reg_val;
      if (rs != REG_AW'(REG_ZERO)) begin
         if (exm_wr_en && (exm_rd == rs)) begin
            value = exm_result;
         end else if (mwb_wr_en && (mwb_rd == rs)) begin
            value = mwb_data;
         end
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register and ALU operand delivery.
//   clk, reset (async, active-high)
//   in_valid/in_ready, id_*      - decoded instruction from ID
//   ex_stall, flush              - downstream hold / squash of the EX slot
//   exm_*, mwb_*                 - EX/MEM and MEM/WB forwarding sources
//   out_valid, alu_a/b, alu_op   - ALU inputs for the EX instruction
//   out_rd/wr_en/is_load/store_data - destination info to EX/MEM
// Build option: DLX_FWD_EN enables operand forwarding with load-use
// stalling; without it the stage interlocks on any RAW against EX or EX/MEM.
module id_ex_operand_stage
   import dlx_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned OP_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [DATA_W-1:0] id_rs1_val,
   input  logic [DATA_W-1:0] id_rs2_val,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wr_en,
   input  logic              id_is_load,
   input  logic              ex_stall,
   input  logic              flush,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic              exm_wr_en,
   input  logic [DATA_W-1:0] exm_result,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic              mwb_wr_en,
   input  logic [DATA_W-1:0] mwb_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_wr_en,
   output logic              out_is_load,
   output logic [DATA_W-1:0] out_store_data
);

   logic              valid_q,   valid_d;
   logic [REG_AW-1:0] rs1_q,     rs1_d;
   logic [REG_AW-1:0] rs2_q,     rs2_d;
   logic [DATA_W-1:0] rs1_val_q, rs1_val_d;
   logic [DATA_W-1:0] rs2_val_q, rs2_val_d;
   logic [DATA_W-1:0] imm_q,     imm_d;
   logic              use_imm_q, use_imm_d;
   logic [OP_W-1:0]   op_q,      op_d;
   logic [REG_AW-1:0] rd_q,      rd_d;
   logic              wr_en_q,   wr_en_d;
   logic              is_load_q, is_load_d;

   logic              hazard;
   logic              load;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;

   // A flushed EX instruction never creates a hazard.
   logic ex_live;
   assign ex_live = valid_q & ~flush & (rd_q != REG_AW'(REG_ZERO));

`ifdef DLX_FWD_EN
   // Only a load in EX cannot be forwarded in time; any rs2 match stalls.
   assign hazard = ex_live & is_load_q & ((id_rs1 == rd_q) | (id_rs2 == rd_q));

   fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd_rs1 (
      .rs         (rs1_q),
      .reg_val    (rs1_val_q),
      .exm_rd     (exm_rd),
      .exm_wr_en  (exm_wr_en),
      .exm_result (exm_result),
      .mwb_rd     (mwb_rd),
      .mwb_wr_en  (mwb_wr_en),
      .mwb_data   (mwb_data),
      .value      (opa)
   );

   fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd_rs2 (
      .rs         (rs2_q),
      .reg_val    (rs2_val_q),
      .exm_rd     (exm_rd),
      .exm_wr_en  (exm_wr_en),
      .exm_result (exm_result),
      .mwb_rd     (mwb_rd),
      .mwb_wr_en  (mwb_wr_en),
      .mwb_data   (mwb_data),
      .value      (opb)
   );
`else
   // No bypass: interlock until the producer reaches MEM/WB, whose write
   // the register file returns in the same cycle (write-first).
   logic ex_hit;
   logic exm_hit;
   assign ex_hit  = ex_live & wr_en_q & ((id_rs1 == rd_q) | (id_rs2 == rd_q));
   assign exm_hit = exm_wr_en & (exm_rd != REG_AW'(REG_ZERO)) &
                    ((id_rs1 == exm_rd) | (id_rs2 == exm_rd));
   assign hazard  = ex_hit | exm_hit;

   assign opa = rs1_val_q;
   assign opb = rs2_val_q;

   logic unused_fwd;
   assign unused_fwd = ^{exm_result, mwb_rd, mwb_wr_en, mwb_data, rs1_q, rs2_q};
`endif

   assign in_ready = ~ex_stall & ~hazard;
   assign load     = in_valid & in_ready & ~ex_stall & ~flush;

   always_comb begin
      valid_d   = valid_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rs1_val_d = rs1_val_q;
      rs2_val_d = rs2_val_q;
      imm_d     = imm_q;
      use_imm_d = use_imm_q;
      op_d      = op_q;
      rd_d      = rd_q;
      wr_en_d   = wr_en_q;
      is_load_d = is_load_q;
      if (load) begin
         valid_d   = 1'b1;
         rs1_d     = id_rs1;
         rs2_d     = id_rs2;
         rs1_val_d = id_rs1_val;
         rs2_val_d = id_rs2_val;
         imm_d     = id_imm;
         use_imm_d = id_use_imm;
         op_d      = id_alu_op;
         rd_d      = id_rd;
         wr_en_d   = id_wr_en;
         is_load_d = id_is_load;
      end else if (flush || !ex_stall) begin
         valid_d   = 1'b0;
         wr_en_d   = 1'b0;
         is_load_d = 1'b0;
         op_d      = OP_W'(BUBBLE_OP);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rs1_val_q <= '0;
         rs2_val_q <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         op_q      <= OP_W'(BUBBLE_OP);
         rd_q      <= '0;
         wr_en_q   <= 1'b0;
         is_load_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rs1_val_q <= rs1_val_d;
         rs2_val_q <= rs2_val_d;
         imm_q     <= imm_d;
         use_imm_q <= use_imm_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         wr_en_q   <= wr_en_d;
         is_load_q <= is_load_d;
      end
   end

   assign out_valid      = valid_q;
   assign alu_a          = opa;
   assign alu_b          = use_imm_q ? imm_q : opb;
   assign out_store_data = opb;
   assign alu_op         = valid_q ? op_q : OP_W'(BUBBLE_OP);
   assign out_rd         = valid_q ? rd_q : '0;
   assign out_wr_en      = valid_q & wr_en_q;
   assign out_is_load    = valid_q & is_load_q;

endmodule
